// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: validates an active-low hsync/vsync pair against the
// configured raster, rebuilds pixel coordinates from the syncs, and reports lock/errors.
module vga_sync_monitor #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        clr_err,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_valid,
    output logic        locked,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        err_hperiod,
    output logic        err_hwidth,
    output logic        err_vperiod,
    output logic        err_vwidth
);

    localparam logic [10:0] HTotal = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] HStart = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HEnd   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  VTotal = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0]  VStart = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VEnd   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [7:0]  HSyncW = 8'(H_SYNC);
    localparam logic [9:0]  VSyncW = 10'(V_SYNC);
    localparam logic [3:0]  LockN  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch = 2'd0, StAcquire = 2'd1, StLocked = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [7:0]  hlow_q, hlow_d;
    logic [9:0]  vlow_q, vlow_d;
    logic        hseen_q, hseen_d, vseen_q, vseen_d;
    logic        hlow_valid_q, hlow_valid_d, vlow_valid_q, vlow_valid_d;
    logic        vpend_q, vpend_d;
    logic [3:0]  good_q, good_d;
    logic        frame_bad_q, frame_bad_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        frame_start_q, frame_start_d;
    logic        err_hper_q, err_hper_d, err_hwid_q, err_hwid_d;
    logic        err_vper_q, err_vper_d, err_vwid_q, err_vwid_d;
    logic [9:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
    logic        rx_valid_q, rx_valid_d;

    logic hfall, hrise, vfall, vrise, anchor;
    logic hper_ev, hwid_ev, vper_ev, vwid_ev, err_ev;
    logic hwin, vwin;

    assign hfall  = hs_prev_q & ~hs_q;
    assign hrise  = ~hs_prev_q & hs_q;
    assign vfall  = vs_prev_q & ~vs_q;
    assign vrise  = ~vs_prev_q & vs_q;
    // A vfall coinciding with hfall makes that same hfall the anchor.
    assign anchor = hfall & (vpend_q | vfall);

    // Counters, event detection and sticky error flags.
    always_comb begin
        hs_d         = hsync;
        hs_prev_d    = hs_q;
        vs_d         = vsync;
        vs_prev_d    = vs_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        hlow_d       = hlow_q;
        vlow_d       = vlow_q;
        hseen_d      = hseen_q;
        vseen_d      = vseen_q;
        hlow_valid_d = hlow_valid_q;
        vlow_valid_d = vlow_valid_q;
        vpend_d      = vpend_q;
        hper_ev      = 1'b0;
        hwid_ev      = 1'b0;
        vper_ev      = 1'b0;
        vwid_ev      = 1'b0;

        if (hfall) begin
            hcount_d     = '0;
            hseen_d      = 1'b1;
            hlow_valid_d = 1'b1;
            if (hseen_q && (hcount_q + 11'd1 != HTotal)) hper_ev = 1'b1;
        end else if (hcount_q != '1) begin
            hcount_d = hcount_q + 11'd1;
        end

        // Width is only judged for a low pulse whose falling edge was observed.
        if (hrise) begin
            if (hlow_valid_q && (hlow_q != HSyncW)) hwid_ev = 1'b1;
            hlow_d = '0;
        end else if (!hs_q && (hlow_q != '1)) begin
            hlow_d = hlow_q + 8'd1;
        end

        if (vfall) begin
            vpend_d      = 1'b1;
            vlow_valid_d = 1'b1;
        end
        if (anchor) begin
            vpend_d  = 1'b0;
            vcount_d = '0;
            vseen_d  = 1'b1;
            if (vseen_q && (vcount_q + 10'd1 != VTotal)) vper_ev = 1'b1;
        end else if (hfall && (vcount_q != '1)) begin
            vcount_d = vcount_q + 10'd1;
        end

        if (vrise) begin
            if (vlow_valid_q && (vlow_q != VSyncW)) vwid_ev = 1'b1;
            vlow_d = '0;
        end else if (hfall && !vs_q && (vlow_q != '1)) begin
            vlow_d = vlow_q + 10'd1;
        end

        err_ev        = hper_ev | hwid_ev | vper_ev | vwid_ev;
        frame_start_d = anchor;
        // A new error in the same cycle as clr_err survives the clear.
        err_hper_d    = (err_hper_q & ~clr_err) | hper_ev;
        err_hwid_d    = (err_hwid_q & ~clr_err) | hwid_ev;
        err_vper_d    = (err_vper_q & ~clr_err) | vper_ev;
        err_vwid_d    = (err_vwid_q & ~clr_err) | vwid_ev;

        hwin       = (hcount_q >= HStart) && (hcount_q <= HEnd);
        vwin       = (vcount_q >= VStart) && (vcount_q <= VEnd);
        rx_x_d     = hwin ? 10'(hcount_q - HStart) : '0;
        rx_y_d     = vwin ? (vcount_q - VStart) : '0;
        rx_valid_d = (state_q == StLocked) && hwin && vwin;
    end

    // Lock state machine.
    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        frame_bad_d   = frame_bad_q;
        frame_count_d = frame_count_q;

        case (state_q)
            StSearch: begin
                if (anchor) begin
                    state_d     = StAcquire;
                    good_d      = '0;
                    frame_bad_d = 1'b0;
                end
            end
            StAcquire: begin
                if (anchor) begin
                    frame_bad_d = 1'b0;
                    if (frame_bad_q || err_ev) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LockN) state_d = StLocked;
                    end
                end else if (err_ev) begin
                    frame_bad_d = 1'b1;
                end
            end
            StLocked: begin
                if (err_ev) begin
                    state_d = StSearch;
                end else if (anchor) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= StSearch;
            hs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_q          <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hlow_q        <= '0;
            vlow_q        <= '0;
            hseen_q       <= 1'b0;
            vseen_q       <= 1'b0;
            hlow_valid_q  <= 1'b0;
            vlow_valid_q  <= 1'b0;
            vpend_q       <= 1'b0;
            good_q        <= '0;
            frame_bad_q   <= 1'b0;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
            err_hper_q    <= 1'b0;
            err_hwid_q    <= 1'b0;
            err_vper_q    <= 1'b0;
            err_vwid_q    <= 1'b0;
            rx_x_q        <= '0;
            rx_y_q        <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            hs_prev_q     <= hs_prev_d;
            vs_q          <= vs_d;
            vs_prev_q     <= vs_prev_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hlow_q        <= hlow_d;
            vlow_q        <= vlow_d;
            hseen_q       <= hseen_d;
            vseen_q       <= vseen_d;
            hlow_valid_q  <= hlow_valid_d;
            vlow_valid_q  <= vlow_valid_d;
            vpend_q       <= vpend_d;
            good_q        <= good_d;
            frame_bad_q   <= frame_bad_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
            err_hper_q    <= err_hper_d;
            err_hwid_q    <= err_hwid_d;
            err_vper_q    <= err_vper_d;
            err_vwid_q    <= err_vwid_d;
            rx_x_q        <= rx_x_d;
            rx_y_q        <= rx_y_d;
            rx_valid_q    <= rx_valid_d;
        end
    end

    assign rx_x        = rx_x_q;
    assign rx_y        = rx_y_q;
    assign rx_valid    = rx_valid_q;
    assign locked      = (state_q == StLocked);
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign err_hperiod = err_hper_q;
    assign err_hwidth  = err_hwid_q;
    assign err_vperiod = err_vper_q;
    assign err_vwidth  = err_vwid_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a shrunken raster: a sync generator drives the DUT while a
// coordinate scoreboard and table of fault frames check lock, errors and pixel stream.
module tb_vga_sync_monitor;

    localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 2;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned BadLine = 3;

    logic        clk = 1'b0;
    logic        rst_n, hsync, vsync, clr_err;
    logic [9:0]  rx_x, rx_y;
    logic        rx_valid, locked, frame_start;
    logic [15:0] frame_count;
    logic        err_hperiod, err_hwidth, err_vperiod, err_vwidth;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_25MHz  (clk),
        .reset      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .clr_err    (clr_err),
        .rx_x       (rx_x),
        .rx_y       (rx_y),
        .rx_valid   (rx_valid),
        .locked     (locked),
        .frame_start(frame_start),
        .frame_count(frame_count),
        .err_hperiod(err_hperiod),
        .err_hwidth (err_hwidth),
        .err_vperiod(err_vperiod),
        .err_vwidth (err_vwidth)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       v;
        logic       chk;
    } exp_t;

    typedef struct {
        int         lines;
        int         vs_lines;
        int         bad_period;
        int         bad_hlow;
        logic [3:0] flags;  // {hperiod, hwidth, vperiod, vwidth}
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[4];
    int   n_vec = 0;
    int   n_bad = 0;
    logic chk_coord = 1'b0;
    int   valid_cnt, fs_cnt;
    logic prev_valid, seen_first;
    logic [9:0] first_x, first_y, last_x, last_y;

    function automatic logic [3:0] errs();
        return {err_hperiod, err_hwidth, err_vperiod, err_vwidth};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // One pixel clock: drive the syncs for raster position (h,l), queue the coordinates the
    // DUT must show three clocks later, and compare the entry that is now due.
    task automatic tick(input int h, input int l, input int hlow, input int vs_lines,
                        input logic clr);
        exp_t e;
        logic hw, vw;
        @(posedge clk);
        #1;
        hsync   = (h >= hlow);
        vsync   = (l >= vs_lines);
        clr_err = clr;
        hw      = (h >= int'(HS + HB)) && (h < int'(HS + HB + HA));
        vw      = (l >= int'(VS + VB)) && (l < int'(VS + VB + VA));
        e.x     = hw ? 10'(h - int'(HS + HB)) : 10'd0;
        e.y     = vw ? 10'(l - int'(VS + VB)) : 10'd0;
        e.v     = hw && vw;
        e.chk   = chk_coord;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() > 3) begin
            e = sbq.pop_front();
            if (e.chk) begin
                n_vec++;
                if ({rx_x, rx_y, rx_valid} !== {e.x, e.y, e.v}) begin
                    n_bad++;
                    $display("FAIL coord: got x=%0d y=%0d v=%0b, expected x=%0d y=%0d v=%0b",
                             rx_x, rx_y, rx_valid, e.x, e.y, e.v);
                end
            end
        end
        if (chk_coord) begin
            if (rx_valid) begin
                valid_cnt++;
                if (!prev_valid && !seen_first) begin
                    seen_first = 1'b1;
                    first_x    = rx_x;
                    first_y    = rx_y;
                end
                last_x = rx_x;
                last_y = rx_y;
            end
            prev_valid = rx_valid;
            if (frame_start) fs_cnt++;
        end
    endtask

    task automatic drive_frame(input int lines, input int vs_lines, input int bad_period,
                               input int bad_hlow, input logic clr);
        for (int l = 0; l < lines; l++) begin
            int period, hl;
            period = (l == int'(BadLine)) ? bad_period : int'(HT);
            hl     = (l == int'(BadLine)) ? bad_hlow : int'(HS);
            for (int h = 0; h < period; h++) tick(h, l, hl, vs_lines, clr && l == 0 && h == 0);
        end
    endtask

    task automatic clean_frame(input logic clr);
        drive_frame(VT, VS, HT, HS, clr);
    endtask

    initial begin
        rst_n   = 1'b1;
        hsync   = 1'b1;
        vsync   = 1'b1;
        clr_err = 1'b0;
        vecs[0] = '{lines: VT,     vs_lines: VS,     bad_period: HT + 1, bad_hlow: HS,
                    flags: 4'b1000};
        vecs[1] = '{lines: VT - 1, vs_lines: VS,     bad_period: HT,     bad_hlow: HS,
                    flags: 4'b0010};
        vecs[2] = '{lines: VT,     vs_lines: VS + 1, bad_period: HT,     bad_hlow: HS,
                    flags: 4'b0001};
        vecs[3] = '{lines: VT,     vs_lines: VS,     bad_period: HT,     bad_hlow: HS - 1,
                    flags: 4'b0100};

        #2 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", 32'({rx_x, rx_y, rx_valid, locked, frame_start, errs()}), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;

        // Acquisition from reset: lock on the third anchor.
        clean_frame(1'b0);
        clean_frame(1'b0);
        check("lock_before_3rd_anchor", 32'(locked), 32'd0);
        clean_frame(1'b0);
        check("lock_after_3rd_anchor", 32'(locked), 32'd1);
        check("clean_errs", 32'(errs()), 32'd0);
        clean_frame(1'b0);
        clean_frame(1'b0);
        check("frame_count_2", 32'(frame_count), 32'd2);

        // Coordinate stream while locked.
        valid_cnt  = 0;
        fs_cnt     = 0;
        prev_valid = 1'b0;
        seen_first = 1'b0;
        first_x    = '1;
        first_y    = '1;
        last_x     = '1;
        last_y     = '1;
        chk_coord  = 1'b1;
        clean_frame(1'b0);
        clean_frame(1'b0);
        chk_coord  = 1'b0;
        check("valid_cycles", 32'(valid_cnt), 32'(2 * HA * VA));
        check("frame_start_pulses", 32'(fs_cnt), 32'd2);
        check("first_pixel", 32'({first_x, first_y}), 32'({10'd0, 10'd0}));
        check("last_pixel", 32'({last_x, last_y}), 32'({10'(HA - 1), 10'(VA - 1)}));
        check("frame_count_4", 32'(frame_count), 32'd4);

        // Short hsync pulse: sticky until clr_err, re-lock three anchors later.
        drive_frame(VT, VS, HT, HS - 1, 1'b0);
        check("hwidth_flags", 32'(errs()), 32'b0100);
        check("hwidth_unlock", 32'(locked), 32'd0);
        clean_frame(1'b0);
        clean_frame(1'b0);
        check("hwidth_relock_early", 32'(locked), 32'd0);
        clean_frame(1'b0);
        check("hwidth_relock", 32'(locked), 32'd1);
        check("hwidth_sticky", 32'(err_hwidth), 32'd1);
        clean_frame(1'b1);
        check("hwidth_cleared", 32'(errs()), 32'd0);
        check("still_locked", 32'(locked), 32'd1);

        // Fault frames from the table, each starting from a freshly locked, cleared state.
        for (int i = 0; i < 4; i++) begin
            clean_frame(1'b1);
            clean_frame(1'b0);
            clean_frame(1'b0);
            clean_frame(1'b0);
            check($sformatf("vec%0d_prelock", i), 32'(locked), 32'd1);
            check($sformatf("vec%0d_preflags", i), 32'(errs()), 32'd0);
            drive_frame(vecs[i].lines, vecs[i].vs_lines, vecs[i].bad_period, vecs[i].bad_hlow,
                        1'b0);
            clean_frame(1'b0);
            check($sformatf("vec%0d_flags", i), 32'(errs()), 32'(vecs[i].flags));
            check($sformatf("vec%0d_unlock", i), 32'(locked), 32'd0);
        end

        // Reset asserted mid-line for ten clocks, generator keeps running.
        for (int l = 0; l < int'(VT); l++) begin
            for (int h = 0; h < int'(HT); h++) begin
                if (l == 5 && h == 10) begin
                    rst_n = 1'b0;
                    #1;
                    check("midreset_outputs",
                          32'({rx_x, rx_y, rx_valid, locked, frame_start, errs()}), 32'd0);
                    check("midreset_frame_count", 32'(frame_count), 32'd0);
                end
                if (l == 5 && h == 20) rst_n = 1'b1;
                tick(h, l, HS, VS, 1'b0);
            end
        end
        check("midreset_partial_errs", 32'(errs()), 32'd0);
        clean_frame(1'b0);
        clean_frame(1'b0);
        check("midreset_lock_early", 32'(locked), 32'd0);
        clean_frame(1'b0);
        check("midreset_lock", 32'(locked), 32'd1);
        check("midreset_errs", 32'(errs()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes the active-low hsync/vsync pair driven by the top level and checks it against 640x480@60 timing.
- Rebuilds the pixel coordinate stream (rx_x, rx_y, rx_valid) from the syncs alone. Reports lock and sticky timing errors.
- Used for on-chip loopback self-test of the display path. Also serves as the monitor in the display-path testbench.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync low width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync low width (lines)
V_BP, 33, vertical back porch (lines)
LOCK_FRAMES, 2, consecutive error-free frames required to lock

Ports:
clk_25MHz  in  1  pixel clock
reset  in  1  asynchronous, active-low
hsync  in  1  horizontal sync, active-low, same clock domain
vsync  in  1  vertical sync, active-low, same clock domain
clr_err  in  1  synchronous clear of sticky error flags
rx_x  out  10  reconstructed pixel column
rx_y  out  10  reconstructed pixel row
rx_valid  out  1  rx_x/rx_y inside visible window while locked
locked  out  1  timing lock achieved
frame_start  out  1  one-cycle pulse on each vertical anchor
frame_count  out  16  anchors seen while locked, wraps at 65535
err_hperiod  out  1  sticky: hsync fall-to-fall period != H_TOTAL
err_hwidth  out  1  sticky: hsync low width != H_SYNC
err_vperiod  out  1  sticky: lines between anchors != V_TOTAL
err_vwidth  out  1  sticky: hsync falls during vsync low != V_SYNC

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset is asynchronous, active-low. All outputs and counters go to 0; FSM enters SEARCH.
- Input stage: hsync/vsync registered once, plus a previous-value register. hfall, hrise, vfall and vrise events are valid 2 clocks after the pin edge.
- hcount (11 b, saturates at 2047):
  - loads 0 on hfall, else increments.
  - On hfall, if hseen, err_hperiod sets when hcount+1 != H_TOTAL. hseen sets on the first hfall.
- hlow (8 b, saturating): counts clocks while registered hsync is low. On hrise, err_hwidth sets when hlow != H_SYNC; hlow then clears.
- vsync handling:
  - vfall sets vpend.
  - The next hfall is the vertical anchor: vcount loads 0, frame_start pulses, vpend clears.
  - Any other hfall increments vcount (10 b, saturating).
  - If vfall and hfall coincide, that same hfall is the anchor.
- vlow: counts hfall events while vsync is low. On vrise, err_vwidth sets when vlow != V_SYNC.
- At each anchor after the first, err_vperiod sets when vcount+1 != V_TOTAL.
- Sticky errors:
  - Cleared only by reset or clr_err.
  - If clr_err coincides with a new error, the error wins (stays 1).
- FSM:
  - SEARCH: on an anchor, go to ACQUIRE with good=0.
  - ACQUIRE: any error event this frame sets frame_bad. At each anchor, good = frame_bad ? 0 : good+1, then frame_bad clears. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1. At each anchor, frame_count increments. Any new error event drops to SEARCH and locked deasserts the next cycle.
- Coordinates (registered, 1 cycle after counters):
  - rx_x = hcount-(H_SYNC+H_BP) when hcount is in [144, 783], else 0.
  - rx_y = vcount-(V_SYNC+V_BP) when vcount is in [35, 514], else 0.
  - rx_valid = locked AND both in window.
  - Pixel (0,0) appears 3 clocks after the pin time of the first visible pixel.
- Reset mid-frame: everything restarts in SEARCH. The first partial line and partial frame are never checked for period.

Test Plan:
1. Compliant 800x525 generator from reset → first anchor enters ACQUIRE, locked=1 after the 3rd anchor; no error flags; frame_count=2 after 2 further anchors.
2. Locked; one line with hsync low for 95 clocks → err_hwidth=1, locked drops, re-locks 3 anchors later; err_hwidth stays 1 until a clr_err pulse clears it.
3. Locked; one line with period 801 → err_hperiod=1, locked=0; other error flags stay 0.
4. Locked; one frame with 524 lines → err_vperiod=1. Separately, vsync low for 3 lines → err_vwidth=1.
5. Locked; check rx_valid and coordinates → rx_valid rises with rx_x=0/rx_y=0 and falls after rx_x=639/rx_y=479; 307200 valid cycles per frame.
6. Assert reset mid-line, release after 10 clocks → all outputs 0 immediately; no spurious errors from the partial line; locked after 3 anchors.
